// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and flag indices for the multi-cycle ALU
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIVU = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_D = 4;
    localparam int NFLAGS = 5;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operation/result handshake bundle between EX control and the ALU
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             Flush;
    logic             InValid;
    logic             InReady;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUOut;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             DivZero;

    modport master (
        output Flush, InValid, ALUOp, Operand1, Operand2, OutReady,
        input  InReady, OutValid, ALUOut, Zero, Negative, Carry, Overflow, DivZero
    );

    modport slave (
        input  Flush, InValid, ALUOp, Operand1, Operand2, OutReady,
        output InReady, OutValid, ALUOut, Zero, Negative, Carry, Overflow, DivZero
    );
endinterface

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - WIDTH-step shift-add multiplier and restoring divider
module alu_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] quo_out
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             mul_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   r_sh;
    logic             r_ge;

    // acc is the partial product for MUL and the partial remainder for DIV;
    // shreg is the multiplier being consumed or the dividend turning into the quotient.
    assign r_sh = {acc, shreg[WIDTH-1]};
    assign r_ge = (r_sh >= {1'b0, opb});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            mul_q <= 1'b0;
            acc   <= '0;
            shreg <= '0;
            opb   <= '0;
        end else if (start) begin
            cnt   <= CW'(WIDTH);
            mul_q <= is_mul;
            acc   <= '0;
            shreg <= a;
            opb   <= b;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (mul_q) begin
                if (shreg[0]) begin
                    acc <= acc + opb;
                end
                shreg <= shreg >> 1;
                opb   <= opb << 1;
            end else if (r_ge) begin
                // A zero divisor always takes this branch: all-ones quotient, remainder = dividend.
                acc   <= r_sh[WIDTH-1:0] - opb;
                shreg <= {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc   <= r_sh[WIDTH-1:0];
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done    = (cnt == '0);
    assign acc_out = acc;
    assign quo_out = shreg;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle EX-stage ALU with valid/ready handshake and NZCV/DivZero flags
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              iter_op;
    logic              iter_done;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [SHW-1:0]    sh;
    logic [WIDTH:0]    add_full;
    logic [WIDTH-1:0]  sub_res;
    logic [WIDTH-1:0]  sc_res;
    logic              sc_c;
    logic              sc_v;
    logic [WIDTH-1:0]  it_acc;
    logic [WIDTH-1:0]  it_quo;
    logic [WIDTH-1:0]  it_res;
    logic [WIDTH-1:0]  alu_out;
    logic [NFLAGS-1:0] flags;
    logic [3:0]        pend_op;
    logic              pend_dz;

    assign a       = bus.Operand1;
    assign b       = bus.Operand2;
    assign sh      = b[SHW-1:0];
    assign iter_op = is_iter(bus.ALUOp);

    assign bus.InReady = (state == ST_IDLE) || ((state == ST_DONE) && bus.OutReady);
    assign accept      = bus.InValid && bus.InReady && !bus.Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept) begin
                    state_nxt = iter_op ? ST_BUSY : ST_DONE;
                end else if (bus.OutReady) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.Flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        sub_res  = a - b;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (bus.ALUOp)
            ALU_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = sub_res;
                sc_c   = (a >= b);
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  sc_res = a & b;
            ALU_OR:   sc_res = a | b;
            ALU_XOR:  sc_res = a ^ b;
            ALU_SLL:  sc_res = a << sh;
            ALU_SRL:  sc_res = a >> sh;
            ALU_SRA:  sc_res = $unsigned($signed(a) >>> sh);
            ALU_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: sc_res = WIDTH'(a < b);
            default:  sc_res = '0;
        endcase
    end

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_op),
        .is_mul (bus.ALUOp == ALU_MUL),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .acc_out(it_acc),
        .quo_out(it_quo)
    );

    assign it_res = (pend_op == ALU_DIVU) ? it_quo : it_acc;

    function automatic logic [NFLAGS-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                     input logic c, input logic v,
                                                     input logic d);
        logic [NFLAGS-1:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_D] = d;
        return f;
    endfunction

    // Flush leaves the last presented result and flags untouched; only the FSM aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            flags   <= '0;
            pend_op <= ALU_ADD;
            pend_dz <= 1'b0;
        end else if (!bus.Flush) begin
            if (accept) begin
                pend_op <= bus.ALUOp;
                pend_dz <= ((bus.ALUOp == ALU_DIVU) || (bus.ALUOp == ALU_REMU)) && (b == '0);
                if (!iter_op) begin
                    alu_out <= sc_res;
                    flags   <= pack_flags(sc_res, sc_c, sc_v, 1'b0);
                end
            end else if ((state == ST_BUSY) && iter_done) begin
                alu_out <= it_res;
                flags   <= pack_flags(it_res, 1'b0, 1'b0, pend_dz);
            end
        end
    end

    assign bus.OutValid = (state == ST_DONE);
    assign bus.ALUOut   = alu_out;
    assign bus.Zero     = flags[FLAG_Z];
    assign bus.Negative = flags[FLAG_N];
    assign bus.Carry    = flags[FLAG_C];
    assign bus.Overflow = flags[FLAG_V];
    assign bus.DivZero  = flags[FLAG_D];

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc with directed vectors
module tb_alu_mc;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flg;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;
    int   shown = 0;
    bit   fresh = 1'b1;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] flg();
        return {bus.DivZero, bus.Overflow, bus.Carry, bus.Negative, bus.Zero};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Flags are {DivZero, Overflow, Carry, Negative, Zero}; lat counts cycles after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] res, input logic [4:0] f,
                        input int lat, input string name);
        int   n;
        exp_t x;
        bus.ALUOp    = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        bus.InValid  = 1'b1;
        n = 0;
        while (!bus.InReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept_timeout"}, 32'(n >= 100), 32'd0);
        if (push) begin
            x.res = res; x.flg = f; x.acc = cyc + 1; x.lat = lat; x.name = name;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    task automatic busy_watch(input string name);
        bit bad = 1'b0;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.OutValid) begin
                seen = 1'b1;
                break;
            end
            if (bus.InReady) bad = 1'b1;
        end
        check({name, "_busy_inready"}, 32'(bad), 32'd0);
        check({name, "_result_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic no_result(input string name, input int ncyc);
        bit seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.OutValid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            fresh = 1'b1;
        end else begin
            if (bus.OutValid && fresh) begin
                shown = cyc;
                fresh = 1'b0;
            end
            if (!bus.OutValid) begin
                fresh = 1'b1;
            end else if (bus.OutReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_res"}, 32'(bus.ALUOut), 32'(e.res));
                    check({e.name, "_flags"}, 32'(flg()), 32'(e.flg));
                    check({e.name, "_latency"}, 32'(shown - e.acc), 32'(e.lat));
                end
                fresh = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.Flush = 1'b0; bus.InValid = 1'b0; bus.OutReady = 1'b1;
        bus.ALUOp = 4'd0; bus.Operand1 = '0; bus.Operand2 = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(bus.ALUOut), 32'd0);
        check("rst_flags", 32'(flg()), 32'd0);
        check("rst_valid", 32'(bus.OutValid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_inready", 32'(bus.InReady), 32'd1);
        check("idle_valid", 32'(bus.OutValid), 32'd0);

        // Back-to-back single-cycle ops
        send(4'd0,  16'd10,   16'hFFFC, 1, 16'h0006, 5'b00100, 0, "add_10_m4");
        send(4'd0,  16'h7FFF, 16'h0001, 1, 16'h8000, 5'b01010, 0, "add_ovf");
        send(4'd7,  16'hFFF6, 16'h0002, 1, 16'hFFFD, 5'b00010, 0, "sra");
        send(4'd6,  16'hFFF6, 16'h0002, 1, 16'h3FFD, 5'b00000, 0, "srl");
        send(4'd8,  16'hFFF6, 16'h0002, 1, 16'h0001, 5'b00000, 0, "slt");
        send(4'd9,  16'hFFF6, 16'h0002, 1, 16'h0000, 5'b00001, 0, "sltu");
        send(4'd1,  16'd5,    16'd7,    1, 16'hFFFE, 5'b00010, 0, "sub_borrow");
        send(4'd5,  16'h0001, 16'h0013, 1, 16'h0008, 5'b00000, 0, "sll_upper_ignored");
        send(4'd2,  16'hF0F0, 16'hFF00, 1, 16'hF000, 5'b00010, 0, "and");
        send(4'd3,  16'h0F00, 16'h00F0, 1, 16'h0FF0, 5'b00000, 0, "or");
        send(4'd4,  16'hAAAA, 16'hAAAA, 1, 16'h0000, 5'b00001, 0, "xor_zero");
        send(4'd14, 16'd5,    16'd5,    1, 16'h0000, 5'b00001, 0, "op14");

        // Iterative ops, WIDTH+1 cycles each
        send(4'd10, 16'd30,   16'd3,    1, 16'd90,   5'b00000, W + 1, "mul_30_3");
        busy_watch("mul_30_3");
        send(4'd10, 16'hFFFF, 16'hFFF7, 1, 16'h0009, 5'b00000, W + 1, "mul_neg");
        busy_watch("mul_neg");
        send(4'd11, 16'd30,   16'd3,    1, 16'd10,   5'b00000, W + 1, "divu_30_3");
        busy_watch("divu_30_3");
        send(4'd12, 16'd30,   16'd3,    1, 16'd0,    5'b00001, W + 1, "remu_30_3");
        busy_watch("remu_30_3");
        send(4'd11, 16'd30,   16'd0,    1, 16'hFFFF, 5'b10010, W + 1, "divu_by0");
        busy_watch("divu_by0");
        send(4'd12, 16'd30,   16'd0,    1, 16'd30,   5'b10000, W + 1, "remu_by0");
        busy_watch("remu_by0");
        drain();

        // Backpressure: result held, then new op accepted on the handshake edge
        @(posedge clk);
        #1;
        bus.OutReady = 1'b0;
        send(4'd4, 16'h1234, 16'h00FF, 1, 16'h12CB, 5'b00000, 0, "bp_xor");
        @(negedge clk);
        check("bp_valid", 32'(bus.OutValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_stable", 32'(bus.ALUOut), 32'h12CB);
            check("bp_flags_stable", 32'(flg()), 32'd0);
            check("bp_inready_low", 32'(bus.InReady), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.OutReady = 1'b1;
        #1;
        check("bp_same_edge_ready", 32'(bus.InReady), 32'd1);
        send(4'd1, 16'h8000, 16'h0001, 1, 16'h7FFF, 5'b01100, 0, "sub_ovf");
        drain();

        // Flush mid-DIVU, then Flush beating a simultaneous accept
        send(4'd11, 16'd30, 16'd3, 0, '0, '0, 0, "divu_flushed");
        repeat (7) @(posedge clk);
        #1;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        check("flush_inready", 32'(bus.InReady), 32'd1);
        check("flush_keeps_out", 32'(bus.ALUOut), 32'h7FFF);
        check("flush_keeps_flags", 32'(flg()), 32'b01100);
        bus.ALUOp = 4'd0; bus.Operand1 = 16'd1; bus.Operand2 = 16'd1;
        bus.InValid = 1'b1;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        bus.Flush = 1'b0;
        no_result("flush_no_result", 30);

        // Async reset mid-DIVU
        send(4'd11, 16'd30, 16'd3, 0, '0, '0, 0, "divu_reset");
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(bus.ALUOut), 32'd0);
        check("arst_flags", 32'(flg()), 32'd0);
        check("arst_valid", 32'(bus.OutValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_inready", 32'(bus.InReady), 32'd1);
        no_result("arst_no_result", 30);
        check("queue_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
